// File: rtl/hop_mover.sv
// Hop/drift position mover for a square sprite: hops in HOP_TICKS steps, lane drift with X clamping.
// Latency: all outputs registered, one cycle after the command; no backpressure (hop_req accepted, rejected or ignored same cycle).
module hop_mover #(
  parameter int COORD_W   = 11,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int OBJ_SIZE  = 20,
  parameter int HOP_DIST  = 20,
  parameter int HOP_TICKS = 4,
  parameter int START_X   = 320,
  parameter int START_Y   = 440
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               tick,
  input  logic               reset_position,
  input  logic               jump,
  input  logic [COORD_W-1:0] jump_x,
  input  logic [COORD_W-1:0] jump_y,
  input  logic               hop_req,
  input  logic [1:0]         hop_dir,
  input  logic               drift_en,
  input  logic               drift_left,
  input  logic [3:0]         drift_speed,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               busy,
  output logic               hop_done,
  output logic               hop_rej,
  output logic               edge_hit
);

  typedef enum logic {IDLE, HOP} state_t;

  localparam int W  = COORD_W + 2;
  localparam int CW = $clog2(HOP_TICKS + 1);

  localparam logic signed [W-1:0] XMAX = W'(SCREEN_W - OBJ_SIZE);
  localparam logic signed [W-1:0] YMAX = W'(SCREEN_H - OBJ_SIZE);
  localparam logic signed [W-1:0] DIST = W'(HOP_DIST);
  localparam logic signed [W-1:0] STEP = W'(HOP_DIST / HOP_TICKS);
  localparam logic signed [W-1:0] ZERO = '0;

  localparam logic [COORD_W-1:0] HOME_X = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] HOME_Y = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] XMAX_U = COORD_W'(SCREEN_W - OBJ_SIZE);
  localparam logic [COORD_W-1:0] YMAX_U = COORD_W'(SCREEN_H - OBJ_SIZE);
  localparam logic [CW-1:0]      LAST   = CW'(HOP_TICKS - 1);

  state_t             state_q, state_n;
  logic [1:0]         dir_q, dir_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [COORD_W-1:0] pos_x_n, pos_y_n;
  logic               done_n, rej_n, edge_n;

  logic signed [W-1:0] cur_x, cur_y, tgt_x, tgt_y, dx, dy, nx, ny, drift;

  always_comb begin
    state_n = state_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    pos_x_n = pos_x;
    pos_y_n = pos_y;
    done_n  = 1'b0;
    rej_n   = 1'b0;
    edge_n  = 1'b0;

    cur_x = {2'b00, pos_x};
    cur_y = {2'b00, pos_y};

    tgt_x = cur_x;
    tgt_y = cur_y;
    case (hop_dir)
      2'd0:    tgt_y = cur_y - DIST;
      2'd1:    tgt_y = cur_y + DIST;
      2'd2:    tgt_x = cur_x - DIST;
      default: tgt_x = cur_x + DIST;
    endcase

    // Hop step and drift combine first; only the sum is clamped.
    dx = '0;
    dy = '0;
    if (state_q == HOP) begin
      case (dir_q)
        2'd0:    dy = -STEP;
        2'd1:    dy = STEP;
        2'd2:    dx = -STEP;
        default: dx = STEP;
      endcase
    end
    drift = {{(W-4){1'b0}}, drift_speed};
    if (drift_en)
      dx = dx + (drift_left ? -drift : drift);
    nx = cur_x + dx;
    ny = cur_y + dy;

    if (reset_position) begin
      state_n = IDLE;
      cnt_n   = '0;
      pos_x_n = HOME_X;
      pos_y_n = HOME_Y;
    end else if (jump) begin
      state_n = IDLE;
      cnt_n   = '0;
      pos_x_n = (jump_x > XMAX_U) ? XMAX_U : jump_x;
      pos_y_n = (jump_y > YMAX_U) ? YMAX_U : jump_y;
    end else begin
      if (state_q == IDLE && hop_req) begin
        if (tgt_x >= ZERO && tgt_x <= XMAX && tgt_y >= ZERO && tgt_y <= YMAX) begin
          state_n = HOP;
          dir_n   = hop_dir;
          cnt_n   = '0;
        end else begin
          rej_n = 1'b1;
        end
      end
      if (tick) begin
        if (state_q == HOP) begin
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end
        end
        // A prechecked hop step cannot leave the screen, so any clamp is drift's doing.
        if (nx < ZERO) begin
          pos_x_n = '0;
          edge_n  = 1'b1;
        end else if (nx > XMAX) begin
          pos_x_n = XMAX_U;
          edge_n  = 1'b1;
        end else begin
          pos_x_n = nx[COORD_W-1:0];
        end
        pos_y_n = ny[COORD_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= IDLE;
      dir_q    <= 2'd0;
      cnt_q    <= '0;
      pos_x    <= HOME_X;
      pos_y    <= HOME_Y;
      hop_done <= 1'b0;
      hop_rej  <= 1'b0;
      edge_hit <= 1'b0;
    end else begin
      state_q  <= state_n;
      dir_q    <= dir_n;
      cnt_q    <= cnt_n;
      pos_x    <= pos_x_n;
      pos_y    <= pos_y_n;
      hop_done <= done_n;
      hop_rej  <= rej_n;
      edge_hit <= edge_n;
    end
  end

  assign busy = (state_q == HOP);

endmodule

// File: tb/tb_hop_mover.sv
// Directed bench for hop_mover: integer behavioural model checked every cycle plus literal checkpoints.
module tb_hop_mover;

  localparam int XM = 620;
  localparam int YM = 460;
  localparam int HX = 320;
  localparam int HY = 440;
  localparam int HSTEP = 5;
  localparam int NTICKS = 4;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        tick, reset_position, jump, hop_req, drift_en, drift_left;
  logic [10:0] jump_x, jump_y;
  logic [1:0]  hop_dir;
  logic [3:0]  drift_speed;
  logic [10:0] pos_x, pos_y;
  logic        busy, hop_done, hop_rej, edge_hit;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  int m_x, m_y, m_dir, m_steps;
  bit m_busy, m_done, m_rej, m_edge;

  hop_mover dut (
    .CLK(CLK), .RESETn(RESETn), .tick(tick), .reset_position(reset_position),
    .jump(jump), .jump_x(jump_x), .jump_y(jump_y), .hop_req(hop_req),
    .hop_dir(hop_dir), .drift_en(drift_en), .drift_left(drift_left),
    .drift_speed(drift_speed), .pos_x(pos_x), .pos_y(pos_y), .busy(busy),
    .hop_done(hop_done), .hop_rej(hop_rej), .edge_hit(edge_hit)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic model_home();
    m_x = HX; m_y = HY; m_busy = 0; m_steps = 0;
    m_done = 0; m_rej = 0; m_edge = 0;
  endtask

  // Expected next state from the behavioural rules, using the inputs sampled at this edge.
  task automatic model_update();
    int tx, ty, nx, ny;
    bit was_busy;
    m_done = 0; m_rej = 0; m_edge = 0;
    if (reset_position) begin
      model_home();
    end else if (jump) begin
      m_x = (int'(jump_x) > XM) ? XM : int'(jump_x);
      m_y = (int'(jump_y) > YM) ? YM : int'(jump_y);
      m_busy = 0;
    end else begin
      was_busy = m_busy;
      if (!m_busy && hop_req) begin
        tx = m_x + (hop_dir == 2 ? -20 : hop_dir == 3 ? 20 : 0);
        ty = m_y + (hop_dir == 0 ? -20 : hop_dir == 1 ? 20 : 0);
        if (tx >= 0 && tx <= XM && ty >= 0 && ty <= YM) begin
          m_busy = 1; m_dir = int'(hop_dir); m_steps = 0;
        end else begin
          m_rej = 1;
        end
      end
      if (tick) begin
        nx = m_x; ny = m_y;
        if (was_busy) begin
          if (m_dir == 0) ny -= HSTEP;
          else if (m_dir == 1) ny += HSTEP;
          else if (m_dir == 2) nx -= HSTEP;
          else nx += HSTEP;
          m_steps++;
          if (m_steps == NTICKS) begin m_busy = 0; m_done = 1; end
        end
        if (drift_en) nx += drift_left ? -int'(drift_speed) : int'(drift_speed);
        if (nx < 0) begin nx = 0; m_edge = 1; end
        else if (nx > XM) begin nx = XM; m_edge = 1; end
        m_x = nx; m_y = ny;
      end
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en && RESETn) begin
      n_total++;
      if (int'(pos_x) == m_x && int'(pos_y) == m_y && busy == m_busy &&
          hop_done == m_done && hop_rej == m_rej && edge_hit == m_edge)
        n_pass++;
      else
        $display("FAIL model t=%0t: got x=%0d y=%0d busy=%0b done=%0b rej=%0b edge=%0b, expected x=%0d y=%0d busy=%0b done=%0b rej=%0b edge=%0b",
                 $time, pos_x, pos_y, busy, hop_done, hop_rej, edge_hit,
                 m_x, m_y, m_busy, m_done, m_rej, m_edge);
    end
  end

  task automatic clk_cycle();
    @(posedge CLK);
    if (RESETn) model_update();
    @(negedge CLK);
    tick = 0; hop_req = 0; jump = 0; reset_position = 0;
  endtask

  task automatic do_jump(input int x, input int y);
    jump = 1; jump_x = 11'(x); jump_y = 11'(y);
    clk_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETn = 0; tick = 0; reset_position = 0; jump = 0; hop_req = 0;
    jump_x = '0; jump_y = '0; hop_dir = '0;
    drift_en = 0; drift_left = 0; drift_speed = '0;
    model_home();
    repeat (3) @(negedge CLK);
    check("reset pos_x", int'(pos_x), 320);
    check("reset pos_y", int'(pos_y), 440);
    check("reset busy", int'(busy), 0);
    check("reset pulses", int'({hop_done, hop_rej, edge_hit}), 0);
    RESETn = 1;
    chk_en = 1;
    clk_cycle();

    // Up hop from home.
    hop_req = 1; hop_dir = 2'd0;
    clk_cycle();
    check("up accept busy", int'(busy), 1);
    check("up accept y", int'(pos_y), 440);
    for (int i = 1; i <= 4; i++) begin
      tick = 1;
      clk_cycle();
      check("up step y", int'(pos_y), 440 - 5 * i);
    end
    check("up hop_done", int'(hop_done), 1);
    check("up busy after", int'(busy), 0);
    clk_cycle();
    check("up done cleared", int'(hop_done), 0);

    // Left hop at the left edge is rejected.
    do_jump(0, 200);
    hop_req = 1; hop_dir = 2'd2;
    clk_cycle();
    check("rej pulse", int'(hop_rej), 1);
    check("rej pos_x", int'(pos_x), 0);
    check("rej busy", int'(busy), 0);
    clk_cycle();
    check("rej cleared", int'(hop_rej), 0);

    // Drift into the left wall clamps on every tick.
    do_jump(3, 200);
    drift_en = 1; drift_left = 1; drift_speed = 4'd5;
    tick = 1; clk_cycle();
    check("clamp1 x", int'(pos_x), 0);
    check("clamp1 edge", int'(edge_hit), 1);
    tick = 1; clk_cycle();
    check("clamp2 x", int'(pos_x), 0);
    check("clamp2 edge", int'(edge_hit), 1);
    drift_speed = 4'd0;
    tick = 1; clk_cycle();
    check("speed0 x", int'(pos_x), 0);
    check("speed0 edge", int'(edge_hit), 0);

    // Right hop with rightward drift of 2.
    drift_en = 0;
    do_jump(100, 300);
    hop_req = 1; hop_dir = 2'd3;
    drift_en = 1; drift_left = 0; drift_speed = 4'd2;
    clk_cycle();
    for (int i = 1; i <= 4; i++) begin
      tick = 1;
      clk_cycle();
      check("hop+drift x", int'(pos_x), 100 + 7 * i);
      check("hop+drift y", int'(pos_y), 300);
    end
    check("hop+drift done", int'(hop_done), 1);

    // hop_req with tick while idle: accept only, drift still applies.
    do_jump(100, 100);
    hop_req = 1; hop_dir = 2'd1; tick = 1;
    clk_cycle();
    check("same-tick x", int'(pos_x), 102);
    check("same-tick y", int'(pos_y), 100);
    check("same-tick busy", int'(busy), 1);
    tick = 1; clk_cycle();
    check("down step1 y", int'(pos_y), 105);
    tick = 1; hop_req = 1; hop_dir = 2'd2;
    clk_cycle();
    check("ignored hop y", int'(pos_y), 110);
    check("ignored hop rej", int'(hop_rej), 0);
    // Jump mid-hop aborts without hop_done.
    do_jump(700, 50);
    check("jump x", int'(pos_x), 620);
    check("jump y", int'(pos_y), 50);
    check("jump busy", int'(busy), 0);
    check("jump no done", int'(hop_done), 0);
    drift_en = 0;
    tick = 1; clk_cycle();
    check("after abort y", int'(pos_y), 50);

    // reset_position beats jump.
    reset_position = 1; jump = 1; jump_x = 11'd5; jump_y = 11'd5;
    clk_cycle();
    check("prio x", int'(pos_x), 320);
    check("prio y", int'(pos_y), 440);

    // Async reset mid-hop.
    hop_req = 1; hop_dir = 2'd0;
    clk_cycle();
    tick = 1; clk_cycle();
    check("pre-reset y", int'(pos_y), 435);
    #2 RESETn = 0;
    model_home();
    #1;
    check("async y", int'(pos_y), 440);
    check("async busy", int'(busy), 0);
    check("async pulses", int'({hop_done, hop_rej, edge_hit}), 0);
    @(negedge CLK);
    RESETn = 1;
    tick = 1; clk_cycle();
    check("post-reset busy", int'(busy), 0);
    check("post-reset y", int'(pos_y), 440);
    clk_cycle();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
